// File: rtl/as_lut_access_arb_if.sv
`default_nettype none
// ============================================================================
// as_lut_access_arb_if : one requester's LUT access handshake and fields
// Rev 1.0
// ============================================================================
interface as_lut_access_arb_if #(
  parameter int LUT_DEPTH_BITS    = 4,
  parameter int NUM_OUTPUT_QUEUES = 8
);
  logic                         req;
  logic                         rd_wr_L;
  logic [LUT_DEPTH_BITS-1:0]    addr;
  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq;
  logic                         wr_protect;
  logic [47:0]                  wr_mac;
  logic                         ack;
  logic                         err;

  modport master (output req, rd_wr_L, addr, wr_oq, wr_protect, wr_mac,
                  input  ack, err);
  modport slave  (input  req, rd_wr_L, addr, wr_oq, wr_protect, wr_mac,
                  output ack, err);
endinterface
`default_nettype wire

// File: rtl/as_lut_access_arb.sv
`default_nettype none
// ============================================================================
// as_lut_access_arb : round-robin arbiter/sequencer for the MAC CAM LUT ports
// Rev 1.0
// ============================================================================
module as_lut_access_arb #(
  parameter int LUT_DEPTH_BITS    = 4,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  as_lut_access_arb_if.slave           port0,
  as_lut_access_arb_if.slave           port1,
  output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
  output logic                         rd_wr_protect,
  output logic [47:0]                  rd_mac,
  output logic [LUT_DEPTH_BITS-1:0]    lut_rd_addr,
  output logic                         lut_rd_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lut_rd_oq,
  input  logic                         lut_rd_wr_protect,
  input  logic [47:0]                  lut_rd_mac,
  input  logic                         lut_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0]    lut_wr_addr,
  output logic                         lut_wr_req,
  output logic [NUM_OUTPUT_QUEUES-1:0] lut_wr_oq,
  output logic                         lut_wr_protect,
  output logic [47:0]                  lut_wr_mac,
  input  logic                         lut_wr_ack,
  output logic [7:0]                   timeout_cnt,
  output logic                         busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                       state, state_nx;
  logic [TW-1:0]                timer, timer_nx;
  logic                         gnt, gnt_nx, last_grant, last_grant_nx;
  logic                         is_rd, is_rd_nx;
  logic [LUT_DEPTH_BITS-1:0]    addr_q, addr_nx;
  logic [NUM_OUTPUT_QUEUES-1:0] oq_q, oq_nx;
  logic                         prot_q, prot_nx;
  logic [47:0]                  mac_q, mac_nx;
  logic                         lut_rd_req_nx, lut_wr_req_nx;
  logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_nx;
  logic                         rd_prot_nx;
  logic [47:0]                  rd_mac_nx;
  logic [7:0]                   tcnt_nx;
  logic [1:0]                   ack_q, ack_nx, err_q, err_nx;
  logic                         busy_nx, done, timed_out;
  logic                         any_req, sel, lut_ack;

  // Round-robin only matters on a tie; a lone requester always wins.
  assign any_req = port0.req | port1.req;
  assign sel     = (port0.req & port1.req) ? ~last_grant : port1.req;
  assign lut_ack = is_rd ? lut_rd_ack : lut_wr_ack;

  assign lut_rd_addr    = addr_q;
  assign lut_wr_addr    = addr_q;
  assign lut_wr_oq      = oq_q;
  assign lut_wr_protect = prot_q;
  assign lut_wr_mac     = mac_q;
  assign port0.ack      = ack_q[0];
  assign port0.err      = err_q[0];
  assign port1.ack      = ack_q[1];
  assign port1.err      = err_q[1];

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    gnt_nx        = gnt;
    last_grant_nx = last_grant;
    is_rd_nx      = is_rd;
    addr_nx       = addr_q;
    oq_nx         = oq_q;
    prot_nx       = prot_q;
    mac_nx        = mac_q;
    lut_rd_req_nx = lut_rd_req;
    lut_wr_req_nx = lut_wr_req;
    rd_oq_nx      = rd_oq;
    rd_prot_nx    = rd_wr_protect;
    rd_mac_nx     = rd_mac;
    tcnt_nx       = timeout_cnt;
    ack_nx        = 2'b00;
    err_nx        = 2'b00;
    done          = 1'b0;
    timed_out     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx        = sel;
          last_grant_nx = sel;
          is_rd_nx      = sel ? port1.rd_wr_L    : port0.rd_wr_L;
          addr_nx       = sel ? port1.addr       : port0.addr;
          oq_nx         = sel ? port1.wr_oq      : port0.wr_oq;
          prot_nx       = sel ? port1.wr_protect : port0.wr_protect;
          mac_nx        = sel ? port1.wr_mac     : port0.wr_mac;
          lut_rd_req_nx = is_rd_nx;
          lut_wr_req_nx = ~is_rd_nx;
          timer_nx      = '0;
          state_nx      = ISSUE;
        end
      end
      ISSUE: begin
        if (lut_ack) begin
          if (is_rd) begin
            rd_oq_nx   = lut_rd_oq;
            rd_prot_nx = lut_rd_wr_protect;
            rd_mac_nx  = lut_rd_mac;
          end
          lut_rd_req_nx = 1'b0;
          lut_wr_req_nx = 1'b0;
          timer_nx      = '0;
          state_nx      = DRAIN;
        end else if (timer == TMAX) begin
          lut_rd_req_nx = 1'b0;
          lut_wr_req_nx = 1'b0;
          done          = 1'b1;
          timed_out     = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DRAIN: begin
        if (!lut_ack) begin
          done = 1'b1;
        end else if (timer == TMAX) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (done) begin
      ack_nx[gnt] = 1'b1;
      err_nx[gnt] = timed_out;
      state_nx    = IDLE;
      if (timed_out && timeout_cnt != 8'hFF)
        tcnt_nx = timeout_cnt + 8'd1;
    end
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      gnt           <= 1'b0;
      last_grant    <= 1'b1;
      is_rd         <= 1'b0;
      addr_q        <= '0;
      oq_q          <= '0;
      prot_q        <= 1'b0;
      mac_q         <= '0;
      lut_rd_req    <= 1'b0;
      lut_wr_req    <= 1'b0;
      rd_oq         <= '0;
      rd_wr_protect <= 1'b0;
      rd_mac        <= '0;
      timeout_cnt   <= '0;
      ack_q         <= 2'b00;
      err_q         <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      gnt           <= gnt_nx;
      last_grant    <= last_grant_nx;
      is_rd         <= is_rd_nx;
      addr_q        <= addr_nx;
      oq_q          <= oq_nx;
      prot_q        <= prot_nx;
      mac_q         <= mac_nx;
      lut_rd_req    <= lut_rd_req_nx;
      lut_wr_req    <= lut_wr_req_nx;
      rd_oq         <= rd_oq_nx;
      rd_wr_protect <= rd_prot_nx;
      rd_mac        <= rd_mac_nx;
      timeout_cnt   <= tcnt_nx;
      ack_q         <= ack_nx;
      err_q         <= err_nx;
      busy          <= busy_nx;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_as_lut_access_arb.sv
`default_nettype none
// ============================================================================
// tb_as_lut_access_arb : directed stimulus with queue-based response checking
// Rev 1.0
// ============================================================================
module tb_as_lut_access_arb;
  localparam int LB = 4;
  localparam int NQ = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  as_lut_access_arb_if #(.LUT_DEPTH_BITS(LB), .NUM_OUTPUT_QUEUES(NQ)) p0 ();
  as_lut_access_arb_if #(.LUT_DEPTH_BITS(LB), .NUM_OUTPUT_QUEUES(NQ)) p1 ();

  logic [NQ-1:0] rd_oq, lut_rd_oq, lut_wr_oq;
  logic          rd_wr_protect, lut_rd_wr_protect, lut_wr_protect;
  logic [47:0]   rd_mac, lut_rd_mac, lut_wr_mac;
  logic [LB-1:0] lut_rd_addr, lut_wr_addr;
  logic          lut_rd_req, lut_wr_req;
  logic          lut_rd_ack = 1'b0, lut_wr_ack = 1'b0;
  logic [7:0]    timeout_cnt;
  logic          busy;

  as_lut_access_arb #(.LUT_DEPTH_BITS(LB), .NUM_OUTPUT_QUEUES(NQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .port0(p0), .port1(p1),
    .rd_oq(rd_oq), .rd_wr_protect(rd_wr_protect), .rd_mac(rd_mac),
    .lut_rd_addr(lut_rd_addr), .lut_rd_req(lut_rd_req), .lut_rd_oq(lut_rd_oq),
    .lut_rd_wr_protect(lut_rd_wr_protect), .lut_rd_mac(lut_rd_mac), .lut_rd_ack(lut_rd_ack),
    .lut_wr_addr(lut_wr_addr), .lut_wr_req(lut_wr_req), .lut_wr_oq(lut_wr_oq),
    .lut_wr_protect(lut_wr_protect), .lut_wr_mac(lut_wr_mac), .lut_wr_ack(lut_wr_ack),
    .timeout_cnt(timeout_cnt), .busy(busy)
  );

  // LUT model: ack ack_dly cycles after req rises, drop one cycle after req falls
  logic [NQ-1:0] m_oq  [16];
  logic          m_pr  [16];
  logic [47:0]   m_mac [16];
  int  ack_dly = 2;
  bit  rd_en = 1'b1, wr_en = 1'b1, rd_stuck = 1'b0;
  int  rd_cnt = 0, wr_cnt = 0;

  assign lut_rd_oq         = m_oq[lut_rd_addr];
  assign lut_rd_wr_protect = m_pr[lut_rd_addr];
  assign lut_rd_mac        = m_mac[lut_rd_addr];

  always @(posedge clk) begin
    if (lut_rd_req) begin
      rd_cnt     <= rd_cnt + 1;
      lut_rd_ack <= rd_en && (rd_cnt + 1 >= ack_dly);
    end else begin
      rd_cnt <= 0;
      if (!rd_stuck) lut_rd_ack <= 1'b0;
    end
    if (lut_wr_req) begin
      wr_cnt     <= wr_cnt + 1;
      lut_wr_ack <= wr_en && (wr_cnt + 1 >= ack_dly);
    end else begin
      wr_cnt     <= 0;
      lut_wr_ack <= 1'b0;
    end
    if (lut_wr_req && lut_wr_ack) begin
      m_oq[lut_wr_addr]  <= lut_wr_oq;
      m_pr[lut_wr_addr]  <= lut_wr_protect;
      m_mac[lut_wr_addr] <= lut_wr_mac;
    end
  end

  typedef struct {
    int            who;
    bit            rd;
    bit            err;
    logic [LB-1:0] addr;
    logic [NQ-1:0] oq;
    logic          pr;
    logic [47:0]   mac;
    logic [NQ-1:0] x_oq;
    logic          x_pr;
    logic [47:0]   x_mac;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            checks = 0;
  int            failures = 0;
  logic [NQ-1:0] l_oq = '0;
  logic          l_pr = 1'b0;
  logic [47:0]   l_mac = '0;
  logic          prev_rd = 1'b0, prev_wr = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0;
  int            lat0, lat1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // For reads oq/pr/mac are the expected LUT contents; cap marks a successful ISSUE ack.
  task automatic expect_acc(input int who, input bit rd, input logic [LB-1:0] a,
                            input logic [NQ-1:0] oq, input logic pr, input logic [47:0] mac,
                            input bit err, input bit cap);
    exp_t x;
    if (cap) begin
      l_oq = oq; l_pr = pr; l_mac = mac;
    end
    x.who = who; x.rd = rd; x.err = err; x.addr = a; x.oq = oq; x.pr = pr; x.mac = mac;
    x.x_oq = l_oq; x.x_pr = l_pr; x.x_mac = l_mac;
    q.push_back(x);
  endtask

  task automatic drive(input int n, input bit rd, input logic [LB-1:0] a,
                       input logic [NQ-1:0] oq, input logic pr, input logic [47:0] mac,
                       output int lat);
    if (n == 0) begin
      p0.rd_wr_L = rd; p0.addr = a; p0.wr_oq = oq; p0.wr_protect = pr; p0.wr_mac = mac; p0.req = 1'b1;
    end else begin
      p1.rd_wr_L = rd; p1.addr = a; p1.wr_oq = oq; p1.wr_protect = pr; p1.wr_mac = mac; p1.req = 1'b1;
    end
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if ((n == 0) ? p0.ack : p1.ack) break;
      if (lat >= 200) begin
        checks++; failures++;
        $display("FAIL ack_wait: requester %0d got no ack within %0d cycles", n, lat);
        break;
      end
    end
    if (n == 0) p0.req = 1'b0; else p1.req = 1'b0;
  endtask

  // Monitor: pops one expectation per ack pulse, checks LUT fields on each req rise.
  always @(negedge clk) begin
    if (!reset) begin
      chk("lut_req_exclusive", 64'(lut_rd_req & lut_wr_req), 64'd0);
      if (((lut_rd_req && !prev_rd) || (lut_wr_req && !prev_wr)) && q.size() > 0) begin
        chk("lut_dir", 64'(lut_rd_req), 64'(q[0].rd));
        chk("lut_addr", 64'(q[0].rd ? lut_rd_addr : lut_wr_addr), 64'(q[0].addr));
        if (!q[0].rd) begin
          chk("lut_wr_oq", 64'(lut_wr_oq), 64'(q[0].oq));
          chk("lut_wr_protect", 64'(lut_wr_protect), 64'(q[0].pr));
          chk("lut_wr_mac", 64'(lut_wr_mac), 64'(q[0].mac));
        end
      end
      chk("err0_without_ack", 64'(p0.err & ~p0.ack), 64'd0);
      chk("err1_without_ack", 64'(p1.err & ~p1.ack), 64'd0);
      if ((prev_a0 && p0.ack) || (prev_a1 && p1.ack)) begin
        checks++; failures++;
        $display("FAIL ack_pulse_width: ack high two cycles in a row");
      end
      if (p0.ack || p1.ack) begin
        chk("ack_both", 64'(p0.ack & p1.ack), 64'd0);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with nothing expected", p0.ack, p1.ack);
        end else begin
          e = q.pop_front();
          chk("ack_who", 64'(p1.ack), 64'(e.who));
          chk("err", 64'(p1.ack ? p1.err : p0.err), 64'(e.err));
          chk("rd_oq", 64'(rd_oq), 64'(e.x_oq));
          chk("rd_wr_protect", 64'(rd_wr_protect), 64'(e.x_pr));
          chk("rd_mac", 64'(rd_mac), 64'(e.x_mac));
        end
      end
    end
    prev_rd = lut_rd_req; prev_wr = lut_wr_req; prev_a0 = p0.ack; prev_a1 = p1.ack;
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_oq[i] = '0; m_pr[i] = 1'b0; m_mac[i] = '0;
    end
    m_oq[3] = 8'h55; m_pr[3] = 1'b1; m_mac[3] = 48'h001122334455;
    p0.req = 1'b0; p0.rd_wr_L = 1'b0; p0.addr = '0; p0.wr_oq = '0; p0.wr_protect = 1'b0; p0.wr_mac = '0;
    p1.req = 1'b0; p1.rd_wr_L = 1'b0; p1.addr = '0; p1.wr_oq = '0; p1.wr_protect = 1'b0; p1.wr_mac = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lut_rd_req", 64'(lut_rd_req), 64'd0);
    chk("rst_lut_wr_req", 64'(lut_wr_req), 64'd0);
    chk("rst_ack", 64'({p0.ack, p1.ack, p0.err, p1.err}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    chk("rst_rd_data", 64'({rd_oq, rd_wr_protect} ^ rd_mac), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Tie right after reset: requester 0 first
    expect_acc(0, 0, 4'd5, 8'hA1, 1'b1, 48'h0A0A0A0A0A01, 0, 0);
    expect_acc(1, 0, 4'd9, 8'hB2, 1'b0, 48'h0B0B0B0B0B02, 0, 0);
    fork
      drive(0, 0, 4'd5, 8'hA1, 1'b1, 48'h0A0A0A0A0A01, lat0);
      drive(1, 0, 4'd9, 8'hB2, 1'b0, 48'h0B0B0B0B0B02, lat1);
    join
    @(posedge clk); #1;

    // Both requesters keep re-requesting: 0,1,0,1
    expect_acc(0, 0, 4'd11, 8'hC3, 1'b0, 48'h0C0C0C0C0C03, 0, 0);
    expect_acc(1, 0, 4'd12, 8'hD4, 1'b1, 48'h0D0D0D0D0D04, 0, 0);
    expect_acc(0, 0, 4'd13, 8'hE5, 1'b0, 48'h0E0E0E0E0E05, 0, 0);
    expect_acc(1, 0, 4'd14, 8'hF6, 1'b1, 48'h0F0F0F0F0F06, 0, 0);
    fork
      begin
        drive(0, 0, 4'd11, 8'hC3, 1'b0, 48'h0C0C0C0C0C03, lat0);
        @(posedge clk); #1;
        drive(0, 0, 4'd13, 8'hE5, 1'b0, 48'h0E0E0E0E0E05, lat0);
      end
      begin
        drive(1, 0, 4'd12, 8'hD4, 1'b1, 48'h0D0D0D0D0D04, lat1);
        @(posedge clk); #1;
        drive(1, 0, 4'd14, 8'hF6, 1'b1, 48'h0F0F0F0F0F06, lat1);
      end
    join
    @(posedge clk); #1;

    // After a lone grant to 0, the next tie goes to 1
    expect_acc(0, 0, 4'd6, 8'h66, 1'b1, 48'h066666666666, 0, 0);
    drive(0, 0, 4'd6, 8'h66, 1'b1, 48'h066666666666, lat0);
    @(posedge clk); #1;
    expect_acc(1, 0, 4'd10, 8'h1A, 1'b0, 48'h101010101010, 0, 0);
    expect_acc(0, 0, 4'd15, 8'h1F, 1'b1, 48'h151515151515, 0, 0);
    fork
      drive(0, 0, 4'd15, 8'h1F, 1'b1, 48'h151515151515, lat0);
      drive(1, 0, 4'd10, 8'h1A, 1'b0, 48'h101010101010, lat1);
    join
    @(posedge clk); #1;

    // Single read, 2-cycle LUT: lut req at t+1, ack at t+6
    expect_acc(0, 1, 4'd3, 8'h55, 1'b1, 48'h001122334455, 0, 1);
    drive(0, 1, 4'd3, 8'h00, 1'b0, 48'h0, lat0);
    chk("read_latency", 64'(lat0), 64'd6);
    @(posedge clk); #1;

    // Read back a written entry, then a write must leave rd_* alone
    expect_acc(1, 1, 4'd5, 8'hA1, 1'b1, 48'h0A0A0A0A0A01, 0, 1);
    drive(1, 1, 4'd5, 8'h00, 1'b0, 48'h0, lat1);
    @(posedge clk); #1;
    expect_acc(0, 0, 4'd7, 8'h77, 1'b0, 48'h777777777777, 0, 0);
    drive(0, 0, 4'd7, 8'h77, 1'b0, 48'h777777777777, lat0);
    @(posedge clk); #1;

    // Stuck-high read ack: data captured, then DRAIN times out
    rd_stuck = 1'b1;
    expect_acc(0, 1, 4'd9, 8'hB2, 1'b0, 48'h0B0B0B0B0B02, 1, 1);
    drive(0, 1, 4'd9, 8'h00, 1'b0, 48'h0, lat0);
    rd_stuck = 1'b0;
    chk("stuck_timeout_cnt", 64'(timeout_cnt), 64'd1);
    @(posedge clk); #1;
    expect_acc(0, 1, 4'd6, 8'h66, 1'b1, 48'h066666666666, 0, 1);
    drive(0, 1, 4'd6, 8'h00, 1'b0, 48'h0, lat0);
    chk("after_stuck_latency", 64'(lat0), 64'd6);
    @(posedge clk); #1;

    // Reset in the cycle after the grant abandons the access
    p0.rd_wr_L = 1'b0; p0.addr = 4'd2; p0.wr_oq = 8'h22; p0.wr_protect = 1'b1;
    p0.wr_mac = 48'h222222222222; p0.req = 1'b1;
    @(posedge clk); #1;
    chk("granted_busy", 64'(busy), 64'd1);
    reset = 1'b1; p0.req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_lut_req", 64'({lut_rd_req, lut_wr_req}), 64'd0);
    chk("midrst_ack", 64'({p0.ack, p1.ack}), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    l_oq = '0; l_pr = 1'b0; l_mac = '0;
    @(posedge clk); #1;
    expect_acc(0, 0, 4'd2, 8'h22, 1'b1, 48'h222222222222, 0, 0);
    drive(0, 0, 4'd2, 8'h22, 1'b1, 48'h222222222222, lat0);
    chk("after_reset_write_latency", 64'(lat0), 64'd6);
    @(posedge clk); #1;

    // Write timeout with no LUT ack: ack/err at t+1+TIMEOUT_CYCLES
    wr_en = 1'b0;
    expect_acc(1, 0, 4'd4, 8'h44, 1'b0, 48'h444444444444, 1, 0);
    drive(1, 0, 4'd4, 8'h44, 1'b0, 48'h444444444444, lat1);
    chk("timeout_latency", 64'(lat1), 64'(TO + 1));
    chk("timeout_lut_wr_req", 64'(lut_wr_req), 64'd0);
    chk("timeout_cnt_1", 64'(timeout_cnt), 64'd1);
    for (int i = 0; i < 299; i++) begin
      @(posedge clk); #1;
      expect_acc(1, 0, 4'd4, 8'h44, 1'b0, 48'h444444444444, 1, 0);
      drive(1, 0, 4'd4, 8'h44, 1'b0, 48'h444444444444, lat1);
    end
    chk("timeout_cnt_sat", 64'(timeout_cnt), 64'd255);
    wr_en = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/as_lut_access_arb.md
# as_lut_access_arb

Two-requester arbiter and sequencer for the anti-spoof MAC CAM LUT direct-access ports (read and write). It shares the LUT's single rd/wr port pair between requester 0 (the register block) and requester 1 (a hardware learning/aging engine). It serializes accesses and converts the LUT's level req/ack handshake into a one-cycle ack pulse per requester. It also bounds every access with a timeout.

## Interface
Parameters:
- LUT_DEPTH_BITS, 4, LUT address width
- NUM_OUTPUT_QUEUES, 8, oq field width
- TIMEOUT_CYCLES, 64, max cycles waiting for LUT ack (>=2)

Ports (n = 0, 1):
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- req_n  in  1  access request; level, held until ack_n
- rd_wr_L_n  in  1  1 = read, 0 = write
- addr_n  in  LUT_DEPTH_BITS  entry address
- wr_oq_n  in  NUM_OUTPUT_QUEUES  write data
- wr_protect_n  in  1  write data
- wr_mac_n  in  48  write data
- ack_n  out  1  one-cycle completion pulse
- err_n  out  1  valid with ack_n; 1 = timed out
- rd_oq  out  NUM_OUTPUT_QUEUES  read result, valid with ack_n
- rd_wr_protect  out  1  read result
- rd_mac  out  48  read result
- lut_rd_addr, lut_rd_req  out  LUT_DEPTH_BITS, 1  to LUT
- lut_rd_oq, lut_rd_wr_protect, lut_rd_mac, lut_rd_ack  in  NUM_OUTPUT_QUEUES, 1, 48, 1  from LUT
- lut_wr_addr, lut_wr_req, lut_wr_oq, lut_wr_protect, lut_wr_mac  out  LUT_DEPTH_BITS, 1, NUM_OUTPUT_QUEUES, 1, 48  to LUT
- lut_wr_ack  in  1  from LUT
- timeout_cnt  out  8  saturating count of timed-out accesses
- busy  out  1  state != IDLE

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state = IDLE, timer = 0, and last_grant = 1.
- lut_ack means lut_rd_ack for reads and lut_wr_ack for writes.
- IDLE:
  - If exactly one req_n is high, grant it.
  - If both are high, grant the requester != last_grant (round-robin).
  - On grant: latch the requester index, rd_wr_L, addr and write fields; set last_grant; assert lut_rd_req or lut_wr_req; drive lut_*_addr and write fields; timer = 0; go ISSUE.
- ISSUE:
  - lut req stays high and the fields stay stable.
  - On lut_ack = 1: for a read, capture lut_rd_oq, lut_rd_wr_protect and lut_rd_mac into the rd_* outputs. Deassert lut req. Go DRAIN.
  - Otherwise, if timer == TIMEOUT_CYCLES-1: deassert lut req, pulse ack_n with err_n = 1, increment timeout_cnt (saturating at 255), go IDLE.
  - Otherwise timer++.
- DRAIN:
  - Wait for lut_ack = 0, then pulse ack_n (err_n = 0) and go IDLE.
  - DRAIN also times out with the same rule; on timeout, ack_n pulses with err_n = 1.
- The non-granted requester is held off; its req stays pending and is served next.
- A requester drops req_n the cycle after ack_n. If req_n is still high in IDLE, it is a new request.
- rd_* outputs keep their last captured value until the next successful read. They do not change on writes or timeouts.
- A req_n withdrawn mid-access is ignored: the access completes and ack_n still pulses.
- lut_rd_req and lut_wr_req are never high together.
- Reset asserted in any state: next cycle all LUT reqs are 0, no ack pulses, state IDLE. In-flight accesses are abandoned without ack.

## Timing
- IDLE sees req_n at cycle t: lut req is high at t+1.
- lut_ack first high at cycle a: lut req is low at a+1.
- lut_ack first seen low in DRAIN at cycle d: ack_n is high at d+1 only. The arbiter is in IDLE at d+1 and may grant again at d+1, with lut req at d+2.
- For a LUT that acks k cycles after req and drops ack 1 cycle after req falls, the minimum access-to-ack latency is k+3 cycles.
- Timeout: lut req rises at t+1; with no ack, ack_n/err_n are high at t+1+TIMEOUT_CYCLES.

## Test plan
- Single read: req_0 with addr = 3, rd_wr_L = 1; LUT returns oq = 0x55 and mac = 0x001122334455 with a 2-cycle ack delay. Expect lut_rd_req only, ack_0 pulse for 1 cycle, err_0 = 0, rd_oq = 0x55, rd_mac = 0x001122334455, and ack_1 never high.
- Simultaneous writes: req_0 and req_1 both rise in the same cycle after reset. Expect requester 0 served first, then requester 1 (lut_wr_addr follows each requester's addr). A repeat tie with both requests held goes 0, 1, 0, 1.
- Timeout: TIMEOUT_CYCLES = 8, lut_wr_ack tied 0, req_1 write. Expect ack_1 and err_1 high exactly 9 cycles after the cycle req was sampled, lut_wr_req low at that point, and timeout_cnt = 1. Driving 300 timeouts gives timeout_cnt = 255.
- Stuck-high ack: lut_rd_ack stays high after lut req drops. Expect a DRAIN timeout with err_n = 1, after which the next access proceeds normally.
- Reset mid-ISSUE: reset in the cycle after the grant. Expect lut_*_req = 0, ack = 0, busy = 0 on the next cycle, and a fresh request to work normally.
- Read-data hold: a write follows a read. Expect the rd_* outputs to be unchanged after the write's ack.
